// File: rtl/queue_reader.sv
// Read-side controller for a small push/read register queue: mirrors occupancy,
// issues read pulses and streams the returned words out through a 2-entry buffer.
module queue_reader #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    output logic             q_rd,
    input  logic [WIDTH-1:0] q_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Encoding doubles as the buffer occupancy (0..2) in the credit check.
    typedef enum logic [1:0] {
        OB_EMPTY = 2'd0,
        OB_ONE   = 2'd1,
        OB_TWO   = 2'd2
    } obuf_e;

    obuf_e             obuf, obuf_nxt;
    logic [WIDTH-1:0]  head, head_nxt;
    logic [WIDTH-1:0]  tail, tail_nxt;
    logic [CW-1:0]     count_nxt;
    logic              pend;
    logic              pop;
    logic              ovf_set;
    logic [2:0]        staged;

    assign m_valid = (obuf != OB_EMPTY);
    assign m_data  = head;
    assign pop     = m_valid && m_ready;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);

    // Words already staged plus the one in flight; a pop this cycle frees a slot,
    // which is why m_ready reaches q_rd combinationally.
    assign staged = {1'b0, obuf} + {2'b00, pend};
    assign q_rd   = !rst && (count != '0) && (staged < (3'd2 + {2'b00, pop}));

    // NOTE: every variable driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        count_nxt = count;
        ovf_set   = 1'b0;
        if (push && !q_rd) begin
            if (count == DEPTH_C) begin
                ovf_set = 1'b1;
            end else begin
                count_nxt = count + 1'b1;
            end
        end else if (!push && q_rd) begin
            count_nxt = count - 1'b1;
        end
    end

    // Head is always the oldest word; the tail shifts into it on a pop.
    always_comb begin
        obuf_nxt = obuf;
        head_nxt = head;
        tail_nxt = tail;
        case (obuf)
            OB_EMPTY: begin
                if (pend) begin
                    head_nxt = q_dout;
                    obuf_nxt = OB_ONE;
                end
            end
            OB_ONE: begin
                case ({pend, pop})
                    2'b11: head_nxt = q_dout;
                    2'b10: begin
                        tail_nxt = q_dout;
                        obuf_nxt = OB_TWO;
                    end
                    2'b01: obuf_nxt = OB_EMPTY;
                    default: ;
                endcase
            end
            OB_TWO: begin
                if (pop) begin
                    head_nxt = tail;
                    if (pend) begin
                        tail_nxt = q_dout;
                    end else begin
                        obuf_nxt = OB_ONE;
                    end
                end
            end
            default: obuf_nxt = OB_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            pend     <= 1'b0;
            overflow <= 1'b0;
            obuf     <= OB_EMPTY;
        end else begin
            count    <= count_nxt;
            pend     <= q_rd;
            overflow <= overflow | ovf_set;
            obuf     <= obuf_nxt;
        end
    end

    // NOTE: the buffer entries are reset too: m_data is architecturally 0 after
    // reset, and the tail is cleared alongside so no entry ever holds X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head_nxt;
            tail <= tail_nxt;
        end
    end

endmodule

// File: tb/tb_queue_reader.sv
// Directed bench for queue_reader (WIDTH=8, DEPTH=3): the attached queue's read
// data is driven by hand on the cycle after each expected q_rd.
module tb_queue_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic       q_rd;
    logic [7:0] q_dout;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [1:0] count;
    logic       empty;
    logic       full;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    queue_reader #(.WIDTH(8), .DEPTH(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .q_rd     (q_rd),
        .q_dout   (q_dout),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, then settle before checks.
    task automatic step(input logic p, input logic r, input logic [7:0] d);
        @(posedge clk);
        #1;
        push    = p;
        m_ready = r;
        q_dout  = d;
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        push    = 1'b0;
        m_ready = 1'b0;
        q_dout  = 8'h00;
        #2;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_q_rd", q_rd, 0);
        chk("rst_m_data", m_data, 8'h00);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single word: push at t, q_rd at t+1, output at t+3 for one cycle.
        step(1, 1, 8'h00);
        chk("sw_t0_count", count, 0);
        chk("sw_t0_q_rd_idle", q_rd, 0);
        step(0, 1, 8'h00);
        chk("sw_t1_count", count, 1);
        chk("sw_t1_q_rd", q_rd, 1);
        step(0, 1, 8'hA5);
        chk("sw_t2_q_rd", q_rd, 0);
        chk("sw_t2_count", count, 0);
        chk("sw_t2_m_valid", m_valid, 0);
        step(0, 1, 8'h5A);
        chk("sw_t3_m_valid", m_valid, 1);
        chk("sw_t3_m_data", m_data, 8'hA5);
        step(0, 1, 8'h5A);
        chk("sw_t4_m_valid", m_valid, 0);
        chk("sw_t4_m_data_hold", m_data, 8'hA5);
        chk("sw_t4_empty", empty, 1);

        // Burst of three: q_rd on three consecutive cycles, outputs back to back.
        step(1, 1, 8'h00);
        chk("bu_b0_count", count, 0);
        step(1, 1, 8'h00);
        chk("bu_b1_count", count, 1);
        chk("bu_b1_q_rd", q_rd, 1);
        step(1, 1, 8'h01);
        chk("bu_b2_q_rd", q_rd, 1);
        chk("bu_b2_count_push_rd", count, 1);
        chk("bu_b2_overflow", overflow, 0);
        chk("bu_b2_m_valid", m_valid, 0);
        step(0, 1, 8'h02);
        chk("bu_b3_q_rd", q_rd, 1);
        chk("bu_b3_m_valid", m_valid, 1);
        chk("bu_b3_m_data", m_data, 8'h01);
        step(0, 1, 8'h03);
        chk("bu_b4_q_rd", q_rd, 0);
        chk("bu_b4_m_data", m_data, 8'h02);
        chk("bu_b4_count", count, 0);
        step(0, 1, 8'hEE);
        chk("bu_b5_m_valid", m_valid, 1);
        chk("bu_b5_m_data", m_data, 8'h03);
        step(0, 1, 8'hEE);
        chk("bu_b6_m_valid", m_valid, 0);

        // Backpressure: three pushes with m_ready low, only two reads issue.
        step(1, 0, 8'h00);
        step(1, 0, 8'h00);
        chk("bp_c1_q_rd", q_rd, 1);
        step(1, 0, 8'h11);
        chk("bp_c2_q_rd", q_rd, 1);
        chk("bp_c2_count", count, 1);
        step(0, 0, 8'h22);
        chk("bp_c3_q_rd", q_rd, 0);
        chk("bp_c3_m_data", m_data, 8'h11);
        chk("bp_c3_m_valid", m_valid, 1);
        step(0, 0, 8'hEE);
        chk("bp_c4_q_rd", q_rd, 0);
        chk("bp_c4_count", count, 1);
        step(0, 0, 8'hEE);
        chk("bp_c5_m_valid", m_valid, 1);
        chk("bp_c5_m_data_stable", m_data, 8'h11);
        chk("bp_c5_q_rd", q_rd, 0);
        step(0, 1, 8'hEE);
        chk("bp_c6_q_rd", q_rd, 1);
        chk("bp_c6_m_data", m_data, 8'h11);
        step(0, 1, 8'h33);
        chk("bp_c7_m_data", m_data, 8'h22);
        chk("bp_c7_count", count, 0);
        chk("bp_c7_q_rd", q_rd, 0);
        step(0, 1, 8'hEE);
        chk("bp_c8_m_data", m_data, 8'h33);
        step(0, 1, 8'hEE);
        chk("bp_c9_m_valid", m_valid, 0);

        // Stage two words with m_ready low, then four pushes to overflow.
        step(1, 0, 8'h00);
        step(0, 0, 8'h00);
        chk("ov_d1_q_rd", q_rd, 1);
        step(1, 0, 8'hAA);
        chk("ov_d2_q_rd", q_rd, 0);
        step(0, 0, 8'hEE);
        chk("ov_d3_q_rd", q_rd, 1);
        chk("ov_d3_m_data", m_data, 8'hAA);
        step(0, 0, 8'hBB);
        chk("ov_d4_q_rd", q_rd, 0);
        step(1, 0, 8'hEE);
        chk("ov_e0_count", count, 0);
        step(1, 0, 8'hEE);
        chk("ov_e1_count", count, 1);
        chk("ov_e1_q_rd", q_rd, 0);
        step(1, 0, 8'hEE);
        chk("ov_e2_count", count, 2);
        chk("ov_e2_overflow", overflow, 0);
        step(1, 0, 8'hEE);
        chk("ov_e3_count", count, 3);
        chk("ov_e3_full", full, 1);
        chk("ov_e3_overflow", overflow, 0);
        step(0, 0, 8'hEE);
        chk("ov_e4_count_sat", count, 3);
        chk("ov_e4_overflow", overflow, 1);
        chk("ov_e4_m_data", m_data, 8'hAA);
        step(0, 1, 8'hEE);
        chk("ov_e5_q_rd", q_rd, 1);
        chk("ov_e5_m_data", m_data, 8'hAA);
        step(0, 1, 8'hC1);
        chk("ov_e6_m_data", m_data, 8'hBB);
        chk("ov_e6_count", count, 2);
        chk("ov_e6_overflow_sticky", overflow, 1);
        chk("ov_e6_q_rd", q_rd, 1);

        // Asynchronous reset mid-cycle with a word in flight.
        #2;
        rst = 1'b1;
        #1;
        chk("mr_m_valid", m_valid, 0);
        chk("mr_count", count, 0);
        chk("mr_overflow", overflow, 0);
        chk("mr_q_rd", q_rd, 0);
        chk("mr_m_data", m_data, 8'h00);
        push    = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_hold_q_rd", q_rd, 0);
        chk("mr_hold_count", count, 0);
        rst  = 1'b0;
        push = 1'b0;
        step(0, 1, 8'hEE);
        chk("mr_after_q_rd", q_rd, 0);
        chk("mr_after_m_valid", m_valid, 0);
        chk("mr_after_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
